// File: rtl/sha256_block_sequencer.sv
// Feeds a padded multi-block message to the external SHA-256 round pipeline one block at a time
// and folds each result into the chaining value. Optional macro SEQ_IV_LOAD_EN adds an iv_in port.
module sha256_block_sequencer #(
    parameter int MAX_BLOCKS = 20,
    parameter int NB_W       = $clog2(MAX_BLOCKS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAX_BLOCKS*512-1:0] msg_in,
    input  logic [NB_W-1:0]           nblocks,
`ifdef SEQ_IV_LOAD_EN
    input  logic [255:0]              iv_in,
`endif
    output logic                      blk_valid,
    input  logic                      blk_ready,
    output logic [511:0]              blk_data,
    output logic [255:0]              blk_state,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic [255:0]              res_state,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [255:0]              digest,
    output logic                      busy
);

    localparam logic [255:0] FIPS_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state;
    logic [511:0]    msg_blocks [MAX_BLOCKS];
    logic [NB_W-1:0] nb_q;
    logic [NB_W-1:0] nb_clamped;
    logic [NB_W-1:0] idx;
    logic [NB_W-1:0] sel;
    logic [255:0]    h_q;
    logic [255:0]    h_init;
    logic            accept;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && (state == IDLE);

`ifdef SEQ_IV_LOAD_EN
    assign h_init = iv_in;
`else
    assign h_init = FIPS_IV;
`endif

    always_comb begin
        nb_clamped = nblocks;
        if (nblocks == '0)
            nb_clamped = NB_W'(1);
        else if (nblocks > NB_W'(MAX_BLOCKS))
            nb_clamped = NB_W'(MAX_BLOCKS);
    end

    // Blocks are issued from the highest-order valid block down to block 0 at the LSB end.
    assign sel       = nb_q - idx - NB_W'(1);
    assign blk_data  = msg_blocks[sel];
    assign blk_state = h_q;
    assign digest    = h_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            nb_q <= nb_clamped;
            for (int i = 0; i < MAX_BLOCKS; i++)
                msg_blocks[i] <= msg_in[i*512 +: 512];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            blk_valid <= 1'b0;
            res_ready <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idx       <= '0;
            h_q       <= FIPS_IV;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        h_q       <= h_init;
                        idx       <= '0;
                        blk_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        res_ready <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (res_valid) begin
                        // Word-wise modulo-2^32 fold of the round output into the chaining value.
                        for (int i = 0; i < 8; i++)
                            h_q[i*32 +: 32] <= h_q[i*32 +: 32] + res_state[i*32 +: 32];
                        idx       <= idx + NB_W'(1);
                        res_ready <= 1'b0;
                        if (idx == nb_q - NB_W'(1)) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            blk_valid <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
